psum_col_collector: RTL

- Downstream stage of a PE column. Consumes the systolic psum stream leaving the top PE (psum_o / flag_psum_valid).
- Accumulates the stream across several passes (input channels / filter rows) into a local buffer, one entry per output position.
- After the final pass, drains the totals to the global buffer over a valid/ready interface.

---
 rtl/eyeriss_pkg.sv | 20 ++
 rtl/psum_col_collector.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/eyeriss_pkg.sv
// Shared types and arithmetic helpers for the Eyeriss-style PE array datapath.
package eyeriss_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} collector_state_t;

  localparam int unsigned PSUM_W = 20;
  localparam int unsigned ACC_W  = 24;

  // Unsigned add clamped to w bits; bit 32 of the result flags a clamp.
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    if (sum > lim) return {1'b1, lim[31:0]};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/psum_col_collector.sv
// Accumulates the PE-column psum stream over several passes into a local
// buffer, then drains the per-position totals over a valid/ready port.
module psum_col_collector
  import eyeriss_pkg::*;
#(
  parameter int unsigned psumWidth = PSUM_W,
  parameter int unsigned accWidth  = ACC_W,
  parameter int unsigned depth     = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [psumWidth-1:0] psum_i,
  input  logic                 psum_valid_i,
  input  logic [7:0]           cfg_npos,
  input  logic [7:0]           cfg_npass,
  input  logic                 ctrl_clear,
  output logic [accWidth-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 flag_busy,
  output logic                 flag_done,
  output logic                 flag_sat,
  output logic                 flag_drop
);

  localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;

  collector_state_t state, state_next;

  logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_idx, rd_next;
  logic [7:0]          pass, npos, npass;
  logic [7:0]          cur_pass, cur_npos, cur_npass;
  logic                wr_en, wr_wrap, wr_last, wr_sat;
  logic                hs, rd_last, drop;
  logic [32:0]         sum_full;
  logic [accWidth-1:0] wr_val;
  logic [accWidth-1:0] acc_mem [depth];

  // Zero means one position; anything beyond the buffer is clamped to it.
  function automatic logic [7:0] norm_npos(input logic [7:0] v);
    if (v == 8'd0) return 8'd1;
    if (v > 8'(depth)) return 8'(depth);
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // The first psum of a job is handled as a write at (pass 0, pos 0) using
  // freshly sampled config, so the wrap/finish logic is shared with ACCUM.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr;
    cur_pass   = pass;
    cur_npos   = npos;
    cur_npass  = npass;
    hs         = 1'b0;
    rd_last    = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (psum_valid_i) begin
          wr_en     = 1'b1;
          wr_idx    = '0;
          cur_pass  = 8'd0;
          cur_npos  = norm_npos(cfg_npos);
          cur_npass = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
        end
      end
      ACCUM: wr_en = psum_valid_i;
      DRAIN: begin
        drop    = psum_valid_i;
        hs      = out_valid & out_ready;
        rd_last = (8'(rd_ptr) == npos - 8'd1);
      end
      default: state_next = IDLE;
    endcase

    wr_wrap = (8'(wr_idx) == cur_npos - 8'd1);
    wr_last = wr_wrap && (cur_pass == cur_npass - 8'd1);
    if (wr_en) state_next = wr_last ? DRAIN : ACCUM;
    if (hs && rd_last) state_next = IDLE;

    if (ctrl_clear) begin
      state_next = IDLE;
      wr_en      = 1'b0;
      hs         = 1'b0;
      drop       = 1'b0;
    end

    rd_next  = rd_ptr + PTR_W'(1);
    sum_full = sat_add(32'(acc_mem[wr_idx]), 32'(psum_i), accWidth);
    wr_sat   = (cur_pass != 8'd0) && sum_full[32];
    wr_val   = (cur_pass == 8'd0) ? accWidth'(psum_i) : accWidth'(sum_full[31:0]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) acc_mem[wr_idx] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (!nrst || ctrl_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass      <= 8'd0;
      npos      <= 8'd1;
      npass     <= 8'd1;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      flag_busy <= 1'b0;
      flag_done <= 1'b0;
      flag_sat  <= 1'b0;
      flag_drop <= 1'b0;
    end else begin
      flag_done <= 1'b0;
      flag_busy <= (state_next != IDLE);
      if (drop) flag_drop <= 1'b1;

      if (wr_en) begin
        npos   <= cur_npos;
        npass  <= cur_npass;
        wr_ptr <= wr_wrap ? '0 : wr_idx + PTR_W'(1);
        pass   <= wr_wrap ? cur_pass + 8'd1 : cur_pass;
        if (wr_last) begin
          rd_ptr <= '0;
          pass   <= 8'd0;
        end
        if (wr_sat) flag_sat <= 1'b1;
      end

      // Output stage: prime with entry 0, then advance one entry per handshake.
      if (state == DRAIN) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= acc_mem[rd_ptr];
          out_last  <= rd_last;
        end else if (hs) begin
          if (rd_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            flag_done <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pass      <= 8'd0;
          end else begin
            rd_ptr   <= rd_next;
            out_data <= acc_mem[rd_next];
            out_last <= (8'(rd_next) == npos - 8'd1);
          end
        end
      end
    end
  end

endmodule
